// File: rtl/pipe_shifter.sv
`default_nettype none
// =============================================================================
// pipe_shifter : multi-cycle barrel shifter (LSL/LSR/ASR/ROR/RRX), STEP bits/cycle
// Option macro : PIPE_SHIFTER_BYPASS_EN (zero-count shifts skip the SHIFT state)
// Revision     : 1.0
// =============================================================================
module pipe_shifter #(
   parameter int WIDTH = 32,
   parameter int STEP  = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [7:0]       in_amt,
   input  logic [1:0]       in_type,
   input  logic             in_rrx,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [3:0]       out_flags
);

   localparam logic [1:0] T_LSL   = 2'b00;
   localparam logic [1:0] T_LSR   = 2'b01;
   localparam logic [1:0] T_ASR   = 2'b10;
   localparam logic [1:0] T_ROR   = 2'b11;
   localparam logic [7:0] C_WIDTH = 8'(WIDTH);
   localparam logic [7:0] C_STEP  = 8'(STEP);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] out_data_q;
   logic [3:0]       out_flags_q;
   logic [7:0]       rem_q;
   logic [1:0]       type_q;
   logic             carry_q;
   logic             cin_q;
   logic             rrx_q;

   logic [7:0]       eff_d;
   logic             carry0_d;
   logic [7:0]       k_d;
   logic [WIDTH:0]   lsl_d;
   logic [WIDTH:0]   lsr_d;
   logic [WIDTH:0]   asr_d;
   logic [WIDTH-1:0] ror_d;
   logic [WIDTH-1:0] step_data_d;
   logic             step_carry_d;

   function automatic logic [3:0] flags_f(input logic [WIDTH-1:0] d, input logic c);
      return {d[WIDTH-1], (d == '0), c, 1'b0};
   endfunction

   // Effective count and the carry a zero-count shift would produce.
   always_comb begin
      eff_d = 8'd0;
      case (in_type)
         T_LSL, T_LSR: eff_d = (in_amt > C_WIDTH + 8'd1) ? C_WIDTH + 8'd1 : in_amt;
         T_ASR:        eff_d = (in_amt > C_WIDTH) ? C_WIDTH : in_amt;
         default:      eff_d = in_rrx ? 8'd1 : (in_amt & (C_WIDTH - 8'd1));
      endcase
      carry0_d = (in_type == T_ROR && !in_rrx && in_amt != 8'd0) ? in_data[WIDTH-1] : in_cin;
   end

   // One SHIFT-cycle step; the extra bit of each widened shift is the carry-out.
   always_comb begin
      k_d          = (rem_q > C_STEP) ? C_STEP : rem_q;
      lsl_d        = {1'b0, data_q} << k_d;
      lsr_d        = {data_q, 1'b0} >> k_d;
      asr_d        = $signed({data_q, 1'b0}) >>> k_d;
      ror_d        = (data_q >> k_d) | (data_q << (C_WIDTH - k_d));
      step_data_d  = data_q;
      step_carry_d = carry_q;
      if (k_d != 8'd0) begin
         if (rrx_q) begin
            step_data_d  = {cin_q, data_q[WIDTH-1:1]};
            step_carry_d = data_q[0];
         end else begin
            case (type_q)
               T_LSL: begin
                  step_data_d  = lsl_d[WIDTH-1:0];
                  step_carry_d = lsl_d[WIDTH];
               end
               T_LSR:   {step_data_d, step_carry_d} = lsr_d;
               T_ASR:   {step_data_d, step_carry_d} = asr_d;
               default: begin
                  step_data_d  = ror_d;
                  step_carry_d = ror_d[WIDTH-1];
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         data_q      <= '0;
         out_data_q  <= '0;
         out_flags_q <= 4'd0;
         rem_q       <= 8'd0;
         type_q      <= 2'd0;
         carry_q     <= 1'b0;
         cin_q       <= 1'b0;
         rrx_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  data_q  <= in_data;
                  carry_q <= carry0_d;
                  cin_q   <= in_cin;
                  type_q  <= in_type;
                  rrx_q   <= (in_type == T_ROR) && in_rrx;
                  rem_q   <= eff_d;
`ifdef PIPE_SHIFTER_BYPASS_EN
                  if (eff_d == 8'd0) begin
                     out_data_q  <= in_data;
                     out_flags_q <= flags_f(in_data, carry0_d);
                     state_q     <= S_DONE;
                  end else begin
                     state_q <= S_SHIFT;
                  end
`else
                  state_q <= S_SHIFT;
`endif
               end
            end
            S_SHIFT: begin
               data_q  <= step_data_d;
               carry_q <= step_carry_d;
               rem_q   <= rem_q - k_d;
               if (rem_q <= C_STEP) begin
                  out_data_q  <= step_data_d;
                  out_flags_q <= flags_f(step_data_d, step_carry_d);
                  state_q     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_data  = out_data_q;
   assign out_flags = out_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_shifter.sv
`default_nettype none
// =============================================================================
// tb_pipe_shifter : directed vector table plus stall / reset sequences (WIDTH=32, STEP=8)
// Revision        : 1.0
// =============================================================================
module tb_pipe_shifter;

   localparam int NV = 18;
`ifdef PIPE_SHIFTER_BYPASS_EN
   localparam int ZE = 0;
`else
   localparam int ZE = 1;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [7:0]  in_amt = '0;
   logic [1:0]  in_type = '0;
   logic        in_rrx = 1'b0;
   logic        in_cin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic [3:0]  out_flags;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_shifter #(.WIDTH(32), .STEP(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_type   (in_type),
      .in_rrx    (in_rrx),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_flags (out_flags)
   );

   typedef struct {
      logic [1:0]  typ;
      logic        rrx;
      logic [7:0]  amt;
      logic [31:0] data;
      logic        cin;
      logic [31:0] exp_data;
      logic [3:0]  exp_flags;
      int          exp_edges;
   } vec_t;

   vec_t vt [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic issue(input vec_t v);
      in_type  = v.typ;
      in_rrx   = v.rrx;
      in_amt   = v.amt;
      in_data  = v.data;
      in_cin   = v.cin;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = ~v.data;
      in_amt   = ~v.amt;
      in_type  = ~v.typ;
      in_rrx   = ~v.rrx;
      in_cin   = ~v.cin;
   endtask

   task automatic wait_done(output int edges);
      edges = 0;
      while (!out_valid && edges < 20) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   e;
      logic seen;

      //        typ    rrx   amt      data          cin   exp_data      flags    edges
      vt[0]  = '{2'b00, 1'b0, 8'd1,   32'h80000001, 1'b0, 32'h00000002, 4'b0010, 1};
      vt[1]  = '{2'b01, 1'b0, 8'd32,  32'h80000000, 1'b0, 32'h00000000, 4'b0110, 4};
      vt[2]  = '{2'b10, 1'b0, 8'd200, 32'h80000000, 1'b0, 32'hFFFFFFFF, 4'b1010, 4};
      vt[3]  = '{2'b11, 1'b0, 8'd36,  32'h000000F1, 1'b0, 32'h1000000F, 4'b0000, 1};
      vt[4]  = '{2'b11, 1'b0, 8'd32,  32'h000000F1, 1'b1, 32'h000000F1, 4'b0000, ZE};
      vt[5]  = '{2'b11, 1'b1, 8'd77,  32'h00000003, 1'b1, 32'h80000001, 4'b1010, 1};
      vt[6]  = '{2'b00, 1'b0, 8'd0,   32'h12345678, 1'b1, 32'h12345678, 4'b0010, ZE};
      vt[7]  = '{2'b00, 1'b0, 8'd32,  32'h00000001, 1'b0, 32'h00000000, 4'b0110, 4};
      vt[8]  = '{2'b00, 1'b0, 8'd33,  32'hFFFFFFFF, 1'b1, 32'h00000000, 4'b0100, 5};
      vt[9]  = '{2'b01, 1'b0, 8'd40,  32'hFFFFFFFF, 1'b1, 32'h00000000, 4'b0100, 5};
      vt[10] = '{2'b10, 1'b0, 8'd4,   32'h7FFFFFF8, 1'b0, 32'h07FFFFFF, 4'b0010, 1};
      vt[11] = '{2'b10, 1'b0, 8'd32,  32'h40000000, 1'b1, 32'h00000000, 4'b0100, 4};
      vt[12] = '{2'b01, 1'b0, 8'd12,  32'h00000F00, 1'b0, 32'h00000000, 4'b0110, 2};
      vt[13] = '{2'b11, 1'b0, 8'd8,   32'h12345678, 1'b1, 32'h78123456, 4'b0000, 1};
      vt[14] = '{2'b00, 1'b0, 8'd9,   32'h00C00000, 1'b0, 32'h80000000, 4'b1010, 2};
      vt[15] = '{2'b10, 1'b0, 8'd0,   32'h80000000, 1'b0, 32'h80000000, 4'b1000, ZE};
      vt[16] = '{2'b11, 1'b0, 8'd0,   32'h80000000, 1'b1, 32'h80000000, 4'b1010, ZE};
      vt[17] = '{2'b10, 1'b0, 8'd31,  32'h80000000, 1'b1, 32'hFFFFFFFF, 4'b1000, 4};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_flags", 64'(out_flags), 64'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // Vector table
      for (int i = 0; i < NV; i++) begin
         chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
         issue(vt[i]);
         wait_done(e);
         chk($sformatf("v%0d_edges", i), 64'(e), 64'(vt[i].exp_edges));
         chk($sformatf("v%0d_data", i), 64'(out_data), 64'(vt[i].exp_data));
         chk($sformatf("v%0d_flags", i), 64'(out_flags), 64'(vt[i].exp_flags));
         @(posedge clk); #1;
         chk($sformatf("v%0d_valid_clear", i), 64'(out_valid), 64'd0);
      end

      // Consumer stalls for 3 cycles while a competing request is offered
      out_ready = 1'b0;
      issue(vt[0]);
      wait_done(e);
      chk("stall_edges", 64'(e), 64'd1);
      in_valid = 1'b1;
      in_data  = 32'hDEADBEEF;
      in_amt   = 8'd3;
      in_type  = 2'b00;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk($sformatf("stall%0d_valid", c), 64'(out_valid), 64'd1);
         chk($sformatf("stall%0d_data", c), 64'(out_data), 64'h00000002);
         chk($sformatf("stall%0d_flags", c), 64'(out_flags), 64'b0010);
         chk($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_release_valid", 64'(out_valid), 64'd0);
      chk("stall_release_in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b0;

      // Reset pulsed mid-SHIFT: result discarded, outputs cleared immediately
      issue(vt[1]);
      @(posedge clk); #1;
      chk("midshift_valid", 64'(out_valid), 64'd0);
      #2 reset_n = 1'b0;
      #1;
      chk("midshift_rst_valid", 64'(out_valid), 64'd0);
      chk("midshift_rst_data", 64'(out_data), 64'd0);
      chk("midshift_rst_flags", 64'(out_flags), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("midshift_discarded", 64'(seen), 64'd0);
      chk("midshift_in_ready", 64'(in_ready), 64'd1);
      issue(vt[2]);
      wait_done(e);
      chk("post_rst_edges", 64'(e), 64'd4);
      chk("post_rst_data", 64'(out_data), 64'hFFFFFFFF);
      chk("post_rst_flags", 64'(out_flags), 64'b1010);
      @(posedge clk); #1;

      // Reset while holding a result in DONE
      out_ready = 1'b0;
      issue(vt[3]);
      wait_done(e);
      chk("done_hold_valid", 64'(out_valid), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("done_rst_valid", 64'(out_valid), 64'd0);
      chk("done_rst_data", 64'(out_data), 64'd0);
      chk("done_rst_flags", 64'(out_flags), 64'd0);
      @(posedge clk); #1;
      reset_n   = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("done_rst_in_ready", 64'(in_ready), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
